// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
// Purpose : bundles the receiver-side write strobe, the bus-side pop, and
//           the status/interrupt signals of the UART receive FIFO into one
//           connection.
// Modports:
//   slave  - the FIFO itself (takes i_* inputs, drives o_* outputs)
//   master - the surrounding logic (UART receiver + Wishbone register block)
// Signals:
//   i_flush      discard all contents
//   i_wr_en      receiver frame-done strobe (one cycle)
//   i_wr_data    9-bit received frame
//   i_rd_en      pop head entry
//   o_rd_data    head entry, 0 when empty
//   o_empty      fill level is zero
//   o_full       fill level is DEPTH
//   o_count      current fill level
//   i_ovf_clr    clear the sticky overflow flag
//   o_overflow   sticky: a frame was dropped because the FIFO was full
//   i_threshold  interrupt fill threshold, 0 disables
//   o_thresh_int level interrupt: fill level has reached the threshold
//   o_timeout    idle timeout flag
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          i_flush;
    logic          i_wr_en;
    logic [8:0]    i_wr_data;
    logic          i_rd_en;
    logic [8:0]    o_rd_data;
    logic          o_empty;
    logic          o_full;
    logic [CW-1:0] o_count;
    logic          i_ovf_clr;
    logic          o_overflow;
    logic [CW-1:0] i_threshold;
    logic          o_thresh_int;
    logic          o_timeout;

    modport slave (
        input  i_flush, i_wr_en, i_wr_data, i_rd_en, i_ovf_clr, i_threshold,
        output o_rd_data, o_empty, o_full, o_count, o_overflow, o_thresh_int,
               o_timeout
    );

    modport master (
        output i_flush, i_wr_en, i_wr_data, i_rd_en, i_ovf_clr, i_threshold,
        input  o_rd_data, o_empty, o_full, o_count, o_overflow, o_thresh_int,
               o_timeout
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Purpose : circular receive buffer between the UART receiver and the bus
//           register interface. Each completed 9-bit frame is pushed on a
//           one-cycle strobe; the bus pops the head entry, which is shown
//           first-word fall-through on o_rd_data. Reports fill level, full,
//           empty, a sticky overflow and a fill-threshold interrupt so the
//           CPU can service several frames per interrupt.
// Ports   :
//   i_clk  system clock
//   i_rst  synchronous active-high reset
//   bus    uart_rx_fifo_if.slave (see interface file for the signal list)
// Parameters:
//   DEPTH          number of 9-bit entries, power of two, >= 2
//   TIMEOUT_CYCLES idle cycles before o_timeout (optional feature only)
// Optional feature:
//   Define UART_RX_FIFO_TIMEOUT_EN to build the idle timeout counter. Without
//   it o_timeout is tied to 0 and TIMEOUT_CYCLES has no effect.
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          i_clk,
    input  logic          i_rst,
    uart_rx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [8:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic w_empty;
    logic w_full;
    logic w_do_rd;
    logic w_do_wr;
    logic w_ovf_set;

    // Status comes straight from the registered count, so every flag moves
    // one cycle after the edge that changed the fill level.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // A pop on an empty FIFO is ignored. A push on a full FIFO is accepted
    // only when a pop frees the head slot in the same cycle.
    assign w_do_rd   = bus.i_rd_en && !w_empty;
    assign w_do_wr   = bus.i_wr_en && (!w_full || w_do_rd);
    assign w_ovf_set = bus.i_wr_en && w_full && !bus.i_rd_en && !bus.i_flush;

    // Storage array is not reset; a flush cycle never writes, so the frame
    // presented alongside a flush is discarded.
    always_ff @(posedge i_clk) begin
        if (w_do_wr && !bus.i_flush) begin
            r_mem[r_wr_ptr] <= bus.i_wr_data;
        end
    end

    // Pointers and fill level. Flush outranks any push/pop in the same
    // cycle. Pointers are exactly AW bits so they wrap on their own.
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow. A drop in the same cycle as a clear wins, so the CPU
    // never loses evidence of a dropped frame. Flush leaves it alone.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end else if (bus.i_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_idle_cnt;

    // Idle counter: restarts on any activity and counts only while frames
    // are waiting, saturating at the limit so the flag holds until serviced.
    // This catches a few frames that never reach the interrupt threshold.
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_flush || w_do_wr || bus.i_rd_en) begin
            r_idle_cnt <= '0;
        end else if (!w_empty && (r_idle_cnt != TW'(TIMEOUT_CYCLES))) begin
            r_idle_cnt <= r_idle_cnt + TW'(1);
        end
    end

    assign bus.o_timeout = (r_idle_cnt == TW'(TIMEOUT_CYCLES));
`else
    assign bus.o_timeout = 1'b0;
`endif

    // Threshold of zero disables the interrupt; a threshold above DEPTH can
    // never be met because the count never exceeds DEPTH.
    assign bus.o_thresh_int = (bus.i_threshold != '0) && (r_count >= bus.i_threshold);

    assign bus.o_rd_data  = w_empty ? 9'h000 : r_mem[r_rd_ptr];
    assign bus.o_empty    = w_empty;
    assign bus.o_full     = w_full;
    assign bus.o_count    = r_count;
    assign bus.o_overflow = r_overflow;
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer between the UART receiver and the Wishbone UART register interface. It captures each completed 9-bit receive frame, which arrives as a one-cycle done strobe with data, into a circular FIFO. The bus side pops entries from the FIFO. The block reports fill level, sticky overflow and a threshold interrupt, so the CPU can service several frames per interrupt instead of one.

Parameters:
DEPTH, 16, number of 9-bit entries; power of two, minimum 2
TIMEOUT_CYCLES, 1024, idle clock cycles before timeout flag (used only with the optional feature)

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous, active-high reset
i_flush  in  1  discard all contents; pointers and count to 0
i_wr_en  in  1  receiver frame-done strobe, one cycle
i_wr_data  in  9  received frame (data bits, LSB aligned)
i_rd_en  in  1  pop head entry (bus read of the RX register)
o_rd_data  out  9  head entry; 0 when empty
o_empty  out  1  count == 0
o_full  out  1  count == DEPTH
o_count  out  $clog2(DEPTH)+1  current fill level
i_ovf_clr  in  1  clear sticky overflow
o_overflow  out  1  sticky: a frame was dropped because the FIFO was full
i_threshold  in  $clog2(DEPTH)+1  interrupt fill threshold; 0 disables
o_thresh_int  out  1  level: threshold != 0 and count >= threshold
o_timeout  out  1  idle timeout flag (constant 0 without the optional feature)

Behaviour:
- Reset: pointers=0, count=0, o_overflow=0, o_timeout=0, o_empty=1, o_full=0, o_thresh_int=0, o_rd_data=0. Memory contents are not reset.
- Storage: DEPTH x 9 register array. Write pointer and read pointer are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- o_rd_data: combinational mem[rd_ptr], gated to 0 when empty (first-word fall-through).
- Write when not full: store at wr_ptr, wr_ptr+1, count+1. The entry is visible on o_rd_data the next cycle.
- Read when not empty: rd_ptr+1, count-1. Data presented before the edge is the popped value.
- Read when empty: ignored; no pointer change, no error.
- Write when full with no read:
  - frame dropped; memory and pointers unchanged
  - o_overflow set the next cycle
- Write and read in the same cycle:
  - not empty and not full: both happen, count unchanged
  - full: read frees the slot, write accepted, count stays DEPTH, no overflow
  - empty: write accepted, read ignored, count becomes 1
- i_flush has priority over rd/wr in the same cycle:
  - pointers and count go to 0; the frame written that cycle is discarded
  - o_overflow is not cleared by flush
- i_ovf_clr clears o_overflow. If an overflow occurs in the same cycle, set wins and the flag stays 1.
- o_count, o_empty, o_full, o_thresh_int are derived from the registered count; all update one cycle after the causing edge.
- Threshold compare is unsigned. A threshold > DEPTH never fires.

Optional Feature:
Macro UART_RX_FIFO_TIMEOUT_EN.
- Defined:
  - Idle counter of $clog2(TIMEOUT_CYCLES+1) bits, cleared by any accepted write, any read, flush or reset.
  - Counts while FIFO is non-empty and saturates at TIMEOUT_CYCLES.
  - o_timeout is set when the counter reaches TIMEOUT_CYCLES and stays set until a read, write or flush clears the counter.
  - Flags frames left below the threshold.
- Not defined: no counter logic; o_timeout tied to 0; TIMEOUT_CYCLES ignored.

Test Plan:
- Reset, write 0x041, 0x142, 0x043 (one per cycle) -> o_count=3, o_rd_data=0x041; three pops return 0x041, 0x142, 0x043; then o_empty=1, o_rd_data=0.
- DEPTH=16: write 17 frames with no reads -> o_full=1, o_count=16, o_overflow=1; contents are frames 0..15 and frame 16 is lost. Pulse i_ovf_clr -> o_overflow=0.
- Fill to 16, then assert i_wr_en and i_rd_en together with data 0x0AA -> count stays 16, no overflow; draining yields frames 1..15 then 0x0AA.
- Pointer wrap: 40 alternating write/read pairs with incrementing data -> every read matches its write; o_count toggles 1/0 throughout.
- i_threshold=4: write 3 -> o_thresh_int=0; 4th write -> 1 the next cycle; one pop -> 0. i_threshold=0 with count 16 -> o_thresh_int stays 0.
- With UART_RX_FIFO_TIMEOUT_EN and TIMEOUT_CYCLES=8: write 1 frame, then idle -> o_timeout=1 after 8 cycles; a pop clears it the next cycle. Without the macro, o_timeout stays 0 throughout.
